soc_reset_sequencer: RTL and testbench

Board-level reset and clock-enable controller that sits between the FPGA pins and the Grande_Risco_5_SOC. It debounces the reset push-button, generates a divided clock-enable pulse so the SoC runs on the board clock without a flop-divided clock, and releases the SoC reset only after a fixed number of enabled cycles. An optional watchdog re-sequences the SoC when software stops kicking it.

---
 rtl/soc_reset_sequencer.sv | 100 ++++++++++
 tb/tb_soc_reset_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/soc_reset_sequencer.sv
// soc_reset_sequencer: button debounce, clock-enable divider and SoC reset sequencing; optional watchdog via RESET_WATCHDOG_EN
module soc_reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES = 16,
  parameter int CLK_DIV = 2,
  parameter int WDT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  input  logic       kick_i,
  output logic       clk_en_o,
  output logic       soc_rst_n_o,
  output logic [1:0] state_o,
  output logic [1:0] reset_cause_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int VW = $clog2(CLK_DIV + 1);
  typedef enum logic [1:0] {ASSERT = 2'b00, HOLD = 2'b01, RUN = 2'b10, BTN = 2'b11} state_t;
  state_t state, state_n;
  logic [1:0] sync, cause_n;
  logic btn_s, btn_db;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic [VW-1:0] div_cnt;
  assign btn_s = sync[1];
  assign state_o = state;
  // two-flop synchroniser followed by a stability counter on the button
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync <= {sync[0], btn_i};
      if (btn_s == btn_db) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  // free-running divider producing a one-cycle enable every CLK_DIV cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      clk_en_o <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == VW'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
      clk_en_o <= (div_cnt == VW'(CLK_DIV - 1));
    end
  // hold counter is zero outside HOLD, so it is cleared on every entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold_cnt <= '0;
    else hold_cnt <= (state != HOLD) ? '0 : hold_cnt + HW'(clk_en_o);
`ifdef RESET_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wdt_cnt;
  // watchdog counts unkicked RUN cycles and idles at zero elsewhere
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdt_cnt <= '0;
    else wdt_cnt <= (state != RUN || kick_i) ? '0 : wdt_cnt + 1'b1;
`else
  logic unused_kick;
  assign unused_kick = kick_i ^ (WDT_CYCLES > 0);
`endif
  // next state and sticky cause; a debounced button overrides everything
  always_comb begin
    state_n = state;
    cause_n = reset_cause_o;
    case (state)
      ASSERT: state_n = HOLD;
      HOLD: if (clk_en_o && hold_cnt == HW'(HOLD_CYCLES - 1)) state_n = RUN;
      RUN: begin
`ifdef RESET_WATCHDOG_EN
        if (!kick_i && wdt_cnt == WW'(WDT_CYCLES - 1)) begin
          state_n = ASSERT;
          cause_n = 2'b10;
        end
`endif
      end
      BTN: if (!btn_db) state_n = HOLD;
    endcase
    if (btn_db && state != BTN) begin
      state_n = BTN;
      cause_n = 2'b01;
    end
  end
  // state, SoC reset and cause registers update on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ASSERT;
      soc_rst_n_o <= 1'b0;
      reset_cause_o <= 2'b00;
    end else begin
      state <= state_n;
      soc_rst_n_o <= (state_n == RUN);
      reset_cause_o <= cause_n;
    end
endmodule

// File: tb/tb_soc_reset_sequencer.sv
// tb_soc_reset_sequencer: table vectors, directed corner sequences and random stimulus against a behavioural model
module tb_soc_reset_sequencer;
  localparam int DEB = 4, HOLD = 3, DIV = 2, WDT = 20;
  logic clk = 1'b0, rst_n = 1'b1, btn = 1'b0, kick = 1'b0;
  logic en, srst;
  logic [1:0] st, cause;
  int checks = 0, errors = 0;
  soc_reset_sequencer #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CLK_DIV(DIV), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst_n(rst_n), .btn_i(btn), .kick_i(kick), .clk_en_o(en),
    .soc_rst_n_o(srst), .state_o(st), .reset_cause_o(cause));
  always #5 clk = ~clk;
  // behavioural model: mode 0 reset, 1 holding, 2 running, 3 button; debounce by a window of the last DEB samples
  int m_edges, m_pulses, m_idle, m_mode, m_cause, nm, nc, diff;
  bit m_s1, m_s2, m_db, m_en, m_srst;
  bit m_hist[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0; m_pulses = 0; m_idle = 0; m_mode = 0; m_cause = 0;
      m_s1 = 0; m_s2 = 0; m_db = 0; m_en = 0; m_srst = 0;
      m_hist.delete();
    end else begin
      nm = m_mode;
      nc = m_cause;
      if (m_mode == 0) nm = 1;
      if (m_mode == 1 && m_en && m_pulses == HOLD - 1) nm = 2;
      if (m_mode == 3 && !m_db) nm = 1;
`ifdef RESET_WATCHDOG_EN
      if (m_mode == 2 && !kick && m_idle == WDT - 1) begin nm = 0; nc = 2; end
`endif
      if (m_db && m_mode != 3) begin nm = 3; nc = 1; end
      m_pulses = (m_mode == 1 && nm == 1) ? m_pulses + int'(m_en) : 0;
      m_idle = (m_mode == 2 && nm == 2 && !kick) ? m_idle + 1 : 0;
      m_hist.push_back(m_s2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      diff = 0;
      foreach (m_hist[i]) if (m_hist[i] != m_db) diff++;
      if (diff == DEB) m_db = !m_db;
      m_s2 = m_s1;
      m_s1 = btn;
      m_edges++;
      m_en = (m_edges % DIV == 0);
      m_mode = nm;
      m_cause = nc;
      m_srst = (nm == 2);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("model state", 32'(st), m_mode);
    chk("model clk_en", 32'(en), 32'(m_en));
    chk("model soc_rst_n", 32'(srst), 32'(m_srst));
    chk("model cause", 32'(cause), m_cause);
  endtask
  typedef struct { logic [1:0] st; logic en; logic srst; logic [1:0] cause; } vec_t;
  vec_t pu[8];
  task automatic power_up();
    rst_n = 1'b0;
    cyc();
    chk("reset state", 32'(st), 0);
    chk("reset clk_en", 32'(en), 0);
    chk("reset soc_rst_n", 32'(srst), 0);
    chk("reset cause", 32'(cause), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("pu state e%0d", i + 1), 32'(st), 32'(pu[i].st));
      chk($sformatf("pu clk_en e%0d", i + 1), 32'(en), 32'(pu[i].en));
      chk($sformatf("pu soc_rst_n e%0d", i + 1), 32'(srst), 32'(pu[i].srst));
      chk($sformatf("pu cause e%0d", i + 1), 32'(cause), 32'(pu[i].cause));
    end
  endtask
  initial begin
    int first, hold_at, run_at, pulses, lows, left;
    logic lvl;
    pu[0] = '{2'b01, 1'b0, 1'b0, 2'b00};
    pu[1] = '{2'b01, 1'b1, 1'b0, 2'b00};
    pu[2] = '{2'b01, 1'b0, 1'b0, 2'b00};
    pu[3] = '{2'b01, 1'b1, 1'b0, 2'b00};
    pu[4] = '{2'b01, 1'b0, 1'b0, 2'b00};
    pu[5] = '{2'b01, 1'b1, 1'b0, 2'b00};
    pu[6] = '{2'b10, 1'b0, 1'b1, 2'b00};
    pu[7] = '{2'b10, 1'b1, 1'b1, 2'b00};
    #1;
    power_up();
    btn = 1'b1;
    repeat (3) cyc();
    btn = 1'b0;
    repeat (12) cyc();
    chk("glitch state", 32'(st), 2);
    chk("glitch soc_rst_n", 32'(srst), 1);
    btn = 1'b1;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (!srst && first == 0) first = i;
    end
    chk("btn latency", first, 7);
    chk("btn state", 32'(st), 3);
    chk("btn cause", 32'(cause), 1);
    btn = 1'b0;
    hold_at = 0; run_at = 0; pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (st == 2'b01 && hold_at == 0) hold_at = i;
      if (st == 2'b01 && en) pulses++;
      if (st == 2'b10 && hold_at != 0 && run_at == 0) run_at = i;
    end
    chk("release hold latency", hold_at, 7);
    chk("release hold pulses", pulses, 3);
    chk("release run reached", 32'(run_at != 0), 1);
`ifdef RESET_WATCHDOG_EN
    power_up();
    for (int e = 9; e <= 28; e++) begin
      cyc();
      if (e == 26) chk("wdt before fire", 32'(st), 2);
      if (e == 27) begin
        chk("wdt fire state", 32'(st), 0);
        chk("wdt fire cause", 32'(cause), 2);
        chk("wdt fire soc_rst_n", 32'(srst), 0);
      end
      if (e == 28) chk("wdt hold", 32'(st), 1);
    end
    repeat (10) cyc();
    chk("wdt rerun state", 32'(st), 2);
    chk("wdt rerun cause", 32'(cause), 2);
    power_up();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      kick = (i % 10 == 0);
      cyc();
      if (!srst) lows++;
    end
    kick = 1'b0;
    chk("kicked no reset", lows, 0);
`else
    power_up();
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (!srst) lows++;
    end
    chk("no wdt no reset", lows, 0);
    chk("no wdt cause", 32'(cause), 0);
`endif
    btn = 1'b1;
    repeat (10) cyc();
    btn = 1'b0;
    for (int i = 0; i < 20 && st != 2'b01; i++) cyc();
    chk("mid hold reached", 32'(st), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async state", 32'(st), 0);
    chk("async clk_en", 32'(en), 0);
    chk("async soc_rst_n", 32'(srst), 0);
    chk("async cause", 32'(cause), 0);
    power_up();
    left = 0;
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        lvl = 1'($urandom_range(1, 0));
        left = $urandom_range(12, 1);
      end
      left--;
      btn = lvl;
      kick = ($urandom_range(24, 0) == 0);
      rst_n = ($urandom_range(400, 0) != 0);
      cyc();
    end
    rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
